// File: rtl/bond_arb.sv
`default_nettype none
// ============================================================================
// Module   : bond_arb
// Purpose  : Two-port burst-aware Avalon-MM arbiter in front of the bonded
//            128-bit DDR slave. Write bursts keep the grant until the last
//            beat; read commands are tagged in a FIFO so return beats are
//            routed back to the port that issued them.
// Options  : BOND_ARB_P0_PRIO_EN - port 0 fixed priority with a port 1
//            starvation guard (STARVE_LIMIT); default is round-robin.
// Revision : 1.0 - initial release
// ============================================================================
module bond_arb #(
  parameter int TAG_DEPTH    = 8,
  parameter int STARVE_LIMIT = 64
) (
  input  logic         csi_clk,
  input  logic         rsi_reset,
  input  logic [25:0]  avs_p0_address,
  input  logic [15:0]  avs_p0_byteenable,
  input  logic         avs_p0_read,
  input  logic         avs_p0_write,
  input  logic [127:0] avs_p0_writedata,
  input  logic [3:0]   avs_p0_burstcount,
  output logic         avs_p0_waitrequest,
  output logic [127:0] avs_p0_readdata,
  output logic         avs_p0_readdatavalid,
  input  logic [25:0]  avs_p1_address,
  input  logic [15:0]  avs_p1_byteenable,
  input  logic         avs_p1_read,
  input  logic         avs_p1_write,
  input  logic [127:0] avs_p1_writedata,
  input  logic [3:0]   avs_p1_burstcount,
  output logic         avs_p1_waitrequest,
  output logic [127:0] avs_p1_readdata,
  output logic         avs_p1_readdatavalid,
  output logic [25:0]  avm_mem_address,
  output logic [15:0]  avm_mem_byteenable,
  output logic         avm_mem_read,
  output logic         avm_mem_write,
  output logic [127:0] avm_mem_writedata,
  output logic [3:0]   avm_mem_burstcount,
  output logic         avm_mem_beginbursttransfer,
  input  logic         avm_mem_waitrequest,
  input  logic [127:0] avm_mem_readdata,
  input  logic         avm_mem_readdatavalid
);

  localparam int c_PTR_W = $clog2(TAG_DEPTH);
  localparam int c_CNT_W = c_PTR_W + 1;

  if (TAG_DEPTH < 2 || TAG_DEPTH > 16 || (TAG_DEPTH & (TAG_DEPTH - 1)) != 0) begin : g_bad_tag_depth
    $error("bond_arb: TAG_DEPTH must be a power of two in 2..16");
  end
  if (STARVE_LIMIT < 1) begin : g_bad_starve_limit
    $error("bond_arb: STARVE_LIMIT must be at least 1");
  end

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    RD_CMD   = 2'd1,
    WR_BURST = 2'd2
  } state_e;

  state_e               state_q, state_d;
  logic                 grant_q, grant_d;
  logic                 last_grant_q, last_grant_d;
  logic [3:0]           wcnt_q, wcnt_d;
  logic                 first_q, first_d;
  logic [4:0]           fifo_q [TAG_DEPTH];
  logic [c_PTR_W-1:0]   wr_ptr_q, rd_ptr_q;
  logic [c_CNT_W-1:0]   fifo_cnt_q, fifo_cnt_d;
  logic [3:0]           rbeat_q;
  logic                 err_orphan_q;

  logic [1:0]   w_req, w_isrd, w_elig, w_wait;
  logic [3:0]   w_bc_n [2];
  logic         w_pick, w_push, w_pop, w_ret, w_full, w_empty;
  logic         w_rd_sel, w_wr_sel;
  logic [3:0]   w_bc_sel;

  // A zero burstcount from a requester is treated as a single beat.
  assign w_bc_n[0] = (avs_p0_burstcount == 4'd0) ? 4'd1 : avs_p0_burstcount;
  assign w_bc_n[1] = (avs_p1_burstcount == 4'd0) ? 4'd1 : avs_p1_burstcount;

  assign w_full  = (fifo_cnt_q == c_CNT_W'(TAG_DEPTH));
  assign w_empty = (fifo_cnt_q == '0);

  // A read cannot be granted while every tag is in flight.
  assign w_req  = {avs_p1_read | avs_p1_write, avs_p0_read | avs_p0_write};
  assign w_isrd = {avs_p1_read, avs_p0_read};
  assign w_elig = w_req & ~(w_isrd & {2{w_full}});

`ifdef BOND_ARB_P0_PRIO_EN
  localparam int c_SW = $clog2(STARVE_LIMIT + 1);
  localparam logic [c_SW-1:0] c_STARVE = c_SW'(STARVE_LIMIT);
  logic [c_SW-1:0] starve_q, starve_d;

  // Port 0 wins contention unless port 1 has waited STARVE_LIMIT cycles.
  always_comb begin
    if (w_elig == 2'b11) w_pick = (starve_q == c_STARVE);
    else                 w_pick = w_elig[1];
  end

  // Saturating wait counter for port 1, cleared when port 1 is granted.
  always_comb begin
    starve_d = starve_q;
    if (state_q == IDLE && (|w_elig) && w_pick)
      starve_d = '0;
    else if (w_req[1] && !(state_q != IDLE && grant_q) && starve_q != c_STARVE)
      starve_d = starve_q + c_SW'(1);
  end

  // Starvation counter register.
  always_ff @(posedge csi_clk or posedge rsi_reset) begin
    if (rsi_reset) starve_q <= '0;
    else           starve_q <= starve_d;
  end
`else
  // Round-robin: on contention the port that did not win last time goes.
  always_comb begin
    if (w_elig == 2'b11) w_pick = ~last_grant_q;
    else                 w_pick = w_elig[1];
  end
`endif

  // Command path is muxed from the granted port and forced to zero in IDLE.
  always_comb begin
    avm_mem_address    = '0;
    avm_mem_byteenable = '0;
    avm_mem_writedata  = '0;
    w_bc_sel           = 4'd0;
    w_rd_sel           = 1'b0;
    w_wr_sel           = 1'b0;
    if (state_q != IDLE) begin
      if (grant_q) begin
        avm_mem_address    = avs_p1_address;
        avm_mem_byteenable = avs_p1_byteenable;
        avm_mem_writedata  = avs_p1_writedata;
        w_bc_sel           = w_bc_n[1];
        w_rd_sel           = avs_p1_read;
        w_wr_sel           = avs_p1_write;
      end else begin
        avm_mem_address    = avs_p0_address;
        avm_mem_byteenable = avs_p0_byteenable;
        avm_mem_writedata  = avs_p0_writedata;
        w_bc_sel           = w_bc_n[0];
        w_rd_sel           = avs_p0_read;
        w_wr_sel           = avs_p0_write;
      end
    end
  end

  assign avm_mem_burstcount         = w_bc_sel;
  assign avm_mem_read               = (state_q == RD_CMD) & w_rd_sel;
  assign avm_mem_write              = (state_q == WR_BURST) & w_wr_sel;
  assign avm_mem_beginbursttransfer = (state_q == WR_BURST) & first_q;
  assign avs_p0_waitrequest         = w_wait[0];
  assign avs_p1_waitrequest         = w_wait[1];

  // Arbitration FSM: next state, grant bookkeeping and port stalls.
  always_comb begin
    state_d      = state_q;
    grant_d      = grant_q;
    last_grant_d = last_grant_q;
    wcnt_d       = wcnt_q;
    first_d      = first_q;
    w_push       = 1'b0;
    w_wait       = 2'b11;
    case (state_q)
      IDLE: begin
        if (|w_elig) begin
          grant_d = w_pick;
          if (w_isrd[w_pick]) begin
            state_d = RD_CMD;
          end else begin
            state_d = WR_BURST;
            wcnt_d  = w_bc_n[w_pick];
            first_d = 1'b1;
          end
        end
      end
      RD_CMD: begin
        if (avm_mem_read && !avm_mem_waitrequest) begin
          w_push          = 1'b1;
          w_wait[grant_q] = 1'b0;
          last_grant_d    = grant_q;
          state_d         = IDLE;
        end
      end
      WR_BURST: begin
        first_d         = 1'b0;
        w_wait[grant_q] = avm_mem_waitrequest;
        if (avm_mem_write && !avm_mem_waitrequest) begin
          wcnt_d = wcnt_q - 4'd1;
          if (wcnt_q <= 4'd1) begin
            wcnt_d       = 4'd0;
            last_grant_d = grant_q;
            state_d      = IDLE;
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // Return beats follow the oldest outstanding read; orphans are dropped.
  assign w_ret                = avm_mem_readdatavalid & ~w_empty;
  assign w_pop                = w_ret & ((rbeat_q + 4'd1) == fifo_q[rd_ptr_q][3:0]);
  assign avs_p0_readdatavalid = w_ret & ~fifo_q[rd_ptr_q][4];
  assign avs_p1_readdatavalid = w_ret & fifo_q[rd_ptr_q][4];
  assign avs_p0_readdata      = w_ret ? avm_mem_readdata : '0;
  assign avs_p1_readdata      = w_ret ? avm_mem_readdata : '0;

  // Tag FIFO occupancy; a push and pop together leave it unchanged.
  always_comb begin
    case ({w_push, w_pop})
      2'b10:   fifo_cnt_d = fifo_cnt_q + c_CNT_W'(1);
      2'b01:   fifo_cnt_d = fifo_cnt_q - c_CNT_W'(1);
      default: fifo_cnt_d = fifo_cnt_q;
    endcase
  end

  // Tag storage: {issuing port, normalised burst length}.
  always_ff @(posedge csi_clk) begin
    if (w_push) fifo_q[wr_ptr_q] <= {grant_q, w_bc_sel};
  end

  // State registers; reset clears everything immediately.
  always_ff @(posedge csi_clk or posedge rsi_reset) begin
    if (rsi_reset) begin
      state_q      <= IDLE;
      grant_q      <= 1'b0;
      last_grant_q <= 1'b1;
      wcnt_q       <= 4'd0;
      first_q      <= 1'b0;
      wr_ptr_q     <= '0;
      rd_ptr_q     <= '0;
      fifo_cnt_q   <= '0;
      rbeat_q      <= 4'd0;
      err_orphan_q <= 1'b0;
    end else begin
      state_q      <= state_d;
      grant_q      <= grant_d;
      last_grant_q <= last_grant_d;
      wcnt_q       <= wcnt_d;
      first_q      <= first_d;
      fifo_cnt_q   <= fifo_cnt_d;
      if (w_push) wr_ptr_q <= wr_ptr_q + c_PTR_W'(1);
      if (w_pop) begin
        rd_ptr_q <= rd_ptr_q + c_PTR_W'(1);
        rbeat_q  <= 4'd0;
      end else if (w_ret) begin
        rbeat_q  <= rbeat_q + 4'd1;
      end
      if (avm_mem_readdatavalid && w_empty) err_orphan_q <= 1'b1;
    end
  end

`ifndef SYNTHESIS
  // A return beat with no outstanding read is a slave protocol error.
  always @(posedge csi_clk) begin
    if (!rsi_reset) begin
      assert (!err_orphan_q) else $error("bond_arb: orphan read-return beat");
    end
  end
`endif

endmodule
`default_nettype wire
